// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown-timer front panel.
//   state_e  : controller states
//   KEY_*    : decoded key codes (digits are 4'h0..4'h9)
//   BLANK    : display code that blanks all four digits
//   key_map  : row/column position to key code
package timer_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        EDIT  = 3'd1,
        LOAD  = 3'd2,
        RUN   = 3'd3,
        PAUSE = 3'd4,
        DONE  = 3'd5
    } state_e;

    localparam logic [3:0]  KEY_STAR     = 4'hA;
    localparam logic [3:0]  KEY_HASH     = 4'hB;
    localparam logic [3:0]  KEY_NONE     = 4'hF;
    localparam logic [15:0] BLANK        = 16'hFFFF;
    localparam logic [3:0]  POINTS_COLON = 4'b0100;

    // Rows 0..2 carry digits 1..9; row 3 is '*', '0', '#'.
    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        if (row == 2'd3) begin
            case (col)
                2'd0:    code = KEY_STAR;
                2'd1:    code = 4'h0;
                2'd2:    code = KEY_HASH;
                default: code = KEY_NONE;
            endcase
        end else begin
            code = 4'({2'b00, row} * 4'd3 + {2'b00, col} + 4'd1);
        end
        return code;
    endfunction

endpackage

// File: rtl/keypad_scan.sv
// 4x3 keypad scanner and debouncer.
//   gclk, rst : clock, asynchronous active-high reset
//   keypadc   : column inputs, active-low
//   keypadr   : row drive, active-low one-hot
//   key_code  : debounced (stable) key code, KEY_NONE when idle
//   key_evt   : one-cycle pulse when a key becomes stable after stable NONE
module keypad_scan
    import timer_pkg::*;
#(
    parameter logic [15:0] SCAN_DIV  = 16'd3999,
    parameter logic [3:0]  DEB_SCANS = 4'd10
) (
    input  logic       gclk,
    input  logic       rst,
    input  logic [2:0] keypadc,
    output logic [3:0] keypadr,
    output logic [3:0] key_code,
    output logic       key_evt
);

    logic [15:0] div_q, div_d;
    logic [1:0]  row_q, row_d;
    logic [3:0]  keypadr_q, keypadr_d;
    logic [1:0]  hits_q, hits_d;      // contacts seen this scan, saturates at 2
    logic [3:0]  acc_q, acc_d;        // code of the first contact this scan
    logic [3:0]  last_q, last_d;
    logic [3:0]  same_q, same_d;
    logic [3:0]  stable_q, stable_d;
    logic        evt_q, evt_d;

    logic        slot_end;
    logic [2:0]  cols;
    logic [1:0]  ncols;
    logic [1:0]  col_idx;
    logic [2:0]  sum3;
    logic [1:0]  hits_sum;
    logic [3:0]  acc_sum;
    logic [3:0]  scan_code;

    // Per-row contact count and merge into the running scan result.
    always_comb begin
        slot_end  = (div_q == SCAN_DIV);
        cols      = ~keypadc;
        ncols     = {1'b0, cols[0]} + {1'b0, cols[1]} + {1'b0, cols[2]};
        col_idx   = cols[0] ? 2'd0 : (cols[1] ? 2'd1 : 2'd2);
        sum3      = {1'b0, hits_q} + {1'b0, ncols};
        hits_sum  = (sum3 > 3'd2) ? 2'd2 : sum3[1:0];
        acc_sum   = (hits_q == 2'd0 && ncols == 2'd1) ? key_map(row_q, col_idx) : acc_q;
        scan_code = (hits_sum == 2'd1) ? acc_sum : KEY_NONE;
    end

    // Scan sequencing and debounce.
    always_comb begin
        div_d     = slot_end ? 16'd0 : div_q + 16'd1;
        row_d     = row_q;
        keypadr_d = keypadr_q;
        hits_d    = hits_q;
        acc_d     = acc_q;
        last_d    = last_q;
        same_d    = same_q;
        stable_d  = stable_q;
        evt_d     = 1'b0;
        if (slot_end) begin
            row_d     = row_q + 2'd1;
            keypadr_d = ~(4'b0001 << row_d);
            if (row_q == 2'd3) begin
                hits_d = 2'd0;
                acc_d  = KEY_NONE;
                if (scan_code == last_q) begin
                    if (same_q != DEB_SCANS) same_d = same_q + 4'd1;
                end else begin
                    last_d = scan_code;
                    same_d = 4'd1;
                end
                // Events only leave stable NONE, so holding a key never repeats.
                if (same_d == DEB_SCANS && scan_code != stable_q) begin
                    stable_d = scan_code;
                    evt_d    = (stable_q == KEY_NONE) && (scan_code != KEY_NONE);
                end
            end else begin
                hits_d = hits_sum;
                acc_d  = acc_sum;
            end
        end
    end

    always_ff @(posedge gclk or posedge rst) begin
        if (rst) begin
            div_q     <= 16'd0;
            row_q     <= 2'd0;
            keypadr_q <= 4'b1110;
            hits_q    <= 2'd0;
            acc_q     <= KEY_NONE;
            last_q    <= KEY_NONE;
            same_q    <= 4'd0;
            stable_q  <= KEY_NONE;
            evt_q     <= 1'b0;
        end else begin
            div_q     <= div_d;
            row_q     <= row_d;
            keypadr_q <= keypadr_d;
            hits_q    <= hits_d;
            acc_q     <= acc_d;
            last_q    <= last_d;
            same_q    <= same_d;
            stable_q  <= stable_d;
            evt_q     <= evt_d;
        end
    end

    assign keypadr  = keypadr_q;
    assign key_code = stable_q;
    assign key_evt  = evt_q;

endmodule

// File: rtl/timer_ctrl.sv
// Countdown-timer front-panel controller: keypad entry, load/run/pause/done
// sequencing and display/switch output muxing.
//   gclk, rst        : clock, asynchronous active-high reset
//   keypadc/keypadr  : keypad columns in / rows out (active-low)
//   tick, cnt_decs   : countdown clock strobe and its BCD value
//   load/load_minute : load request and BCD minutes to load
//   count_en, switch : high only while running
//   decs, points     : display digits and decimal points
module timer_ctrl
    import timer_pkg::*;
#(
    parameter logic [15:0] SCAN_DIV  = 16'd3999,
    parameter logic [3:0]  DEB_SCANS = 4'd10,
    parameter logic [4:0]  BLINK_BIT = 5'd20
) (
    input  logic        gclk,
    input  logic        rst,
    input  logic [2:0]  keypadc,
    output logic [3:0]  keypadr,
    input  logic        tick,
    input  logic [15:0] cnt_decs,
    output logic        load,
    output logic [7:0]  load_minute,
    output logic        count_en,
    output logic [15:0] decs,
    output logic [3:0]  points,
    output logic        switch
);

    localparam int unsigned BLINK_W = 32'(BLINK_BIT) + 1;

    logic [3:0] key_code;
    logic       key_evt;

    keypad_scan #(
        .SCAN_DIV  (SCAN_DIV),
        .DEB_SCANS (DEB_SCANS)
    ) u_scan (
        .gclk     (gclk),
        .rst      (rst),
        .keypadc  (keypadc),
        .keypadr  (keypadr),
        .key_code (key_code),
        .key_evt  (key_evt)
    );

    state_e             state_q, state_d;
    logic [7:0]         entry_q, entry_d;
    logic [BLINK_W-1:0] blink_q;
    logic               load_q, load_d;
    logic [7:0]         load_minute_q, load_minute_d;
    logic               count_en_q, count_en_d;
    logic               switch_q, switch_d;
    logic [15:0]        decs_q, decs_d;
    logic [3:0]         points_q, points_d;

    logic is_digit, is_star, is_hash;

    // Next state and entry buffer; a key beats a coincident tick in RUN.
    always_comb begin
        state_d  = state_q;
        entry_d  = entry_q;
        is_digit = key_evt && (key_code <= 4'h9);
        is_star  = key_evt && (key_code == KEY_STAR);
        is_hash  = key_evt && (key_code == KEY_HASH);
        case (state_q)
            IDLE, EDIT: begin
                if (is_digit) begin
                    entry_d = {entry_q[3:0], key_code};
                    state_d = EDIT;
                end else if (is_hash) begin
                    if (entry_q != 8'h00)     state_d = LOAD;
                    else                      state_d = IDLE;
                end else if (is_star && state_q == EDIT) begin
                    entry_d = 8'h00;
                    state_d = IDLE;
                end
            end
            LOAD: begin
                if (tick) state_d = RUN;
            end
            RUN: begin
                if (is_hash) begin
                    state_d = PAUSE;
                end else if (is_star) begin
                    entry_d = 8'h00;
                    state_d = IDLE;
                end else if (tick && cnt_decs == 16'h0000) begin
                    state_d = DONE;
                end
            end
            PAUSE: begin
                if (is_hash)      state_d = RUN;
                else if (is_star) state_d = IDLE;
            end
            DONE: begin
                if (key_evt) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are derived from the next state so they register with it.
    always_comb begin
        load_d        = (state_d == LOAD);
        load_minute_d = entry_d;
        count_en_d    = (state_d == RUN);
        switch_d      = (state_d == RUN);
        points_d      = POINTS_COLON;
        case (state_d)
            RUN, PAUSE: decs_d = cnt_decs;
            DONE:       decs_d = blink_q[BLINK_W-1] ? cnt_decs : BLANK;
            default:    decs_d = {entry_d, 8'h00};
        endcase
    end

    always_ff @(posedge gclk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            entry_q       <= 8'h00;
            blink_q       <= '0;
            load_q        <= 1'b0;
            load_minute_q <= 8'h00;
            count_en_q    <= 1'b0;
            switch_q      <= 1'b0;
            decs_q        <= 16'h0000;
            points_q      <= POINTS_COLON;
        end else begin
            state_q       <= state_d;
            entry_q       <= entry_d;
            blink_q       <= blink_q + BLINK_W'(1);
            load_q        <= load_d;
            load_minute_q <= load_minute_d;
            count_en_q    <= count_en_d;
            switch_q      <= switch_d;
            decs_q        <= decs_d;
            points_q      <= points_d;
        end
    end

    assign load        = load_q;
    assign load_minute = load_minute_q;
    assign count_en    = count_en_q;
    assign switch      = switch_q;
    assign decs        = decs_q;
    assign points      = points_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl: directed scenarios followed by random
// key/tick traffic compared against a behavioural front-panel model.
`timescale 1ns/1ps
module tb_timer_ctrl;
    import timer_pkg::*;

    localparam logic [15:0] SCAN_DIV  = 16'd3;
    localparam logic [3:0]  DEB_SCANS = 4'd2;
    localparam logic [4:0]  BLINK_BIT = 5'd3;
    localparam int          SCAN_CYC  = 4 * (int'(SCAN_DIV) + 1);

    logic        gclk = 1'b0;
    logic        rst  = 1'b1;
    logic [2:0]  keypadc;
    logic [3:0]  keypadr;
    logic        tick = 1'b0;
    logic [15:0] cnt_decs = 16'h0000;
    logic        load;
    logic [7:0]  load_minute;
    logic        count_en;
    logic [15:0] decs;
    logic [3:0]  points;
    logic        switch;

    timer_ctrl #(
        .SCAN_DIV  (SCAN_DIV),
        .DEB_SCANS (DEB_SCANS),
        .BLINK_BIT (BLINK_BIT)
    ) dut (
        .gclk        (gclk),
        .rst         (rst),
        .keypadc     (keypadc),
        .keypadr     (keypadr),
        .tick        (tick),
        .cnt_decs    (cnt_decs),
        .load        (load),
        .load_minute (load_minute),
        .count_en    (count_en),
        .decs        (decs),
        .points      (points),
        .switch      (switch)
    );

    always #5 gclk = ~gclk;

    // Physical keypad: a pressed key pulls its column low while its row is driven.
    logic       press_on = 1'b0;
    logic [1:0] press_row = 2'd0;
    logic [1:0] press_col = 2'd0;
    always_comb begin
        keypadc = 3'b111;
        if (press_on && keypadr[press_row] == 1'b0) keypadc[press_col] = 1'b0;
    end

    int         evt_cnt = 0;
    logic [3:0] last_code = 4'hF;
    always @(negedge gclk) begin
        if (dut.key_evt) begin
            evt_cnt   = evt_cnt + 1;
            last_code = dut.key_code;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    typedef enum int {M_IDLE, M_EDIT, M_LOAD, M_RUN, M_PAUSE, M_DONE} mode_t;
    mode_t m_mode  = M_IDLE;
    int    m_entry = 0;

    task automatic model_key(input logic [3:0] k);
        bit dig;
        dig = (k <= 4'h9);
        case (m_mode)
            M_IDLE, M_EDIT: begin
                if (dig) begin
                    m_entry = (m_entry % 16) * 16 + int'(k);
                    m_mode  = M_EDIT;
                end else if (k == 4'hB) begin
                    m_mode = (m_entry != 0) ? M_LOAD : M_IDLE;
                end else if (k == 4'hA && m_mode == M_EDIT) begin
                    m_entry = 0;
                    m_mode  = M_IDLE;
                end
            end
            M_LOAD: ;
            M_RUN: begin
                if (k == 4'hB) m_mode = M_PAUSE;
                else if (k == 4'hA) begin
                    m_mode  = M_IDLE;
                    m_entry = 0;
                end
            end
            M_PAUSE: begin
                if (k == 4'hB) m_mode = M_RUN;
                else if (k == 4'hA) m_mode = M_IDLE;
            end
            M_DONE: m_mode = M_IDLE;
            default: ;
        endcase
    endtask

    task automatic model_tick(input logic [15:0] v);
        if (m_mode == M_LOAD) m_mode = M_RUN;
        else if (m_mode == M_RUN && v == 16'h0000) m_mode = M_DONE;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic set_key(input logic [3:0] code);
        int d;
        if (code >= 4'h1 && code <= 4'h9) begin
            d = int'(code) - 1;
            press_row = 2'(d / 3);
            press_col = 2'(d % 3);
        end else begin
            press_row = 2'd3;
            press_col = (code == 4'hA) ? 2'd0 : ((code == 4'hB) ? 2'd2 : 2'd1);
        end
    endtask

    task automatic check_outputs();
        int n_on, n_off, n_bad;
        check("load", 32'(load), 32'(m_mode == M_LOAD));
        if (m_mode == M_LOAD) check("load_minute", 32'(load_minute), 32'(m_entry));
        check("count_en", 32'(count_en), 32'(m_mode == M_RUN));
        check("switch", 32'(switch), 32'(m_mode == M_RUN));
        check("points", 32'(points), 32'h4);
        if (m_mode == M_DONE) begin
            n_on = 0; n_off = 0; n_bad = 0;
            repeat (32) begin
                @(negedge gclk);
                if (decs == cnt_decs) n_on++;
                else if (decs == 16'hFFFF) n_off++;
                else n_bad++;
            end
            check("done_blink_on", 32'(n_on != 0), 32'd1);
            check("done_blink_off", 32'(n_off != 0), 32'd1);
            check("done_blink_other", 32'(n_bad), 32'd0);
        end else if (m_mode == M_RUN || m_mode == M_PAUSE) begin
            check("decs_count", 32'(decs), 32'(cnt_decs));
        end else begin
            check("decs_entry", 32'(decs), 32'(m_entry * 256));
        end
    endtask

    // Press one key long enough to be accepted, then release it fully.
    task automatic press(input logic [3:0] code, input bit collide);
        int    e0, coll_ticks;
        mode_t prev;
        e0 = evt_cnt;
        coll_ticks = 0;
        set_key(code);
        press_on = 1'b1;
        repeat (5 * SCAN_CYC) begin
            @(negedge gclk);
            if (collide) begin
                tick = dut.key_evt;
                if (dut.key_evt) begin
                    cnt_decs = 16'h0000;
                    coll_ticks++;
                end
            end
        end
        tick = 1'b0;
        press_on = 1'b0;
        repeat (5 * SCAN_CYC) @(negedge gclk);
        check("key_evt_count", 32'(evt_cnt - e0), 32'd1);
        check("key_code", 32'(last_code), 32'(code));
        prev = m_mode;
        model_key(code);
        if (collide) begin
            check("collision_tick", 32'(coll_ticks), 32'd1);
            if (m_mode == prev) model_tick(16'h0000);
        end
        check_outputs();
    endtask

    task automatic do_tick(input logic [15:0] v);
        @(negedge gclk);
        cnt_decs = v;
        tick = 1'b1;
        @(negedge gclk);
        tick = 1'b0;
        repeat (2) @(negedge gclk);
        model_tick(v);
        check_outputs();
    endtask

    task automatic sync_scan();
        int n;
        n = 0;
        while (keypadr != 4'b0111 && n < 64) begin @(negedge gclk); n++; end
        while (keypadr != 4'b1110 && n < 64) begin @(negedge gclk); n++; end
        check("scan_sync", 32'(n < 64), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0]  exp_r;
        logic [15:0] v;
        int          r, e0;

        // Reset values
        repeat (3) @(negedge gclk);
        check("rst_keypadr", 32'(keypadr), 32'hE);
        check("rst_load", 32'(load), 32'd0);
        check("rst_load_minute", 32'(load_minute), 32'd0);
        check("rst_count_en", 32'(count_en), 32'd0);
        check("rst_switch", 32'(switch), 32'd0);
        check("rst_decs", 32'(decs), 32'd0);
        check("rst_points", 32'(points), 32'h4);
        rst = 1'b0;

        // 1. Row scan with no key
        for (int i = 0; i < 16; i++) begin
            exp_r = ~(4'b0001 << (i / 4));
            check("scan_row", 32'(keypadr), 32'(exp_r));
            @(negedge gclk);
        end
        repeat (4 * SCAN_CYC) @(negedge gclk);
        check("idle_no_evt", 32'(evt_cnt), 32'd0);

        // 2. Bouncing '5' accepted once
        sync_scan();
        e0 = evt_cnt;
        set_key(4'h5);
        for (int s = 0; s < 6; s++) begin
            press_on = (s % 2 == 0);
            repeat (SCAN_CYC) @(negedge gclk);
        end
        press_on = 1'b1;
        repeat (2 * SCAN_CYC) @(negedge gclk);
        press_on = 1'b0;
        repeat (5 * SCAN_CYC) @(negedge gclk);
        check("bounce_evt_count", 32'(evt_cnt - e0), 32'd1);
        check("bounce_code", 32'(last_code), 32'h5);
        model_key(4'h5);
        check_outputs();
        check("bounce_decs", 32'(decs), 32'h0500);
        check("bounce_state", 32'(dut.state_q), 32'(EDIT));

        // 3. Entry 1,2,3 then '#'
        press(4'h1, 1'b0);
        press(4'h2, 1'b0);
        press(4'h3, 1'b0);
        press(4'hB, 1'b0);
        check("entry_load", 32'(load), 32'd1);
        check("entry_minute", 32'(load_minute), 32'h23);
        repeat (3 * SCAN_CYC) @(negedge gclk);
        check_outputs();
        do_tick(16'h2259);
        check("start_count_en", 32'(count_en), 32'd1);

        // 4. Pause / resume
        press(4'hB, 1'b0);
        press(4'hB, 1'b0);

        // 5. Done and exit
        do_tick(16'h0000);
        press(4'h5, 1'b0);
        check("done_exit_decs", 32'(decs), 32'h2300);

        // 6. Asynchronous reset mid-RUN
        press(4'hB, 1'b0);
        do_tick(16'h0123);
        @(posedge gclk);
        #2 rst = 1'b1;
        #1;
        check("arst_switch", 32'(switch), 32'd0);
        check("arst_count_en", 32'(count_en), 32'd0);
        check("arst_load", 32'(load), 32'd0);
        repeat (2) @(negedge gclk);
        rst = 1'b0;
        m_mode = M_IDLE;
        m_entry = 0;
        @(negedge gclk);
        check("arst_state", 32'(dut.state_q), 32'(IDLE));
        check_outputs();

        // 7. Key and terminal tick in the same cycle
        press(4'h4, 1'b0);
        press(4'hB, 1'b0);
        do_tick(16'h0100);
        press(4'hB, 1'b1);
        check("collision_state", 32'(dut.state_q), 32'(PAUSE));

        // Random traffic
        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 9);
            if (r < 3) begin
                v = ($urandom_range(0, 1) == 0) ? 16'h0000 : 16'($urandom_range(1, 16'h9959));
                do_tick(v);
            end else if (r < 6) begin
                press(4'($urandom_range(0, 9)), 1'b0);
            end else if (r < 8) begin
                press(4'hB, 1'b0);
            end else begin
                press(4'hA, 1'b0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
